serial_seq_detector: RTL and testbench

- Serial pattern detector that consumes the registered single-bit stream produced by the D flip-flop stage (its q output drives din).
- Keeps a shift history of the last PAT_LEN accepted bits and pulses match when the history equals PATTERN.
- Counts matches in a saturating counter for status/debug readout.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/serial_seq_detector_if.sv | 28 ++
 rtl/sat_counter.sv | 26 ++
 rtl/serial_seq_detector.sv | 91 +++++++++
 tb/tb_serial_seq_detector.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants, fill-width helper and history state type for the serial sequence detector.
package seq_det_pkg;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_COUNT_W = 8;

    // FILLING while fewer than PAT_LEN bits are held, ARMED once the history is full.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } hist_state_e;

    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/serial_seq_detector_if.sv
// Bit-stream input and match/status output bundle of the serial sequence detector.
interface serial_seq_detector_if
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int COUNT_W = DEF_COUNT_W
);

    localparam int FILL_W = fill_w(PAT_LEN);

    logic               din_valid;
    logic               din;
    logic               clear;
    logic               match;
    logic [COUNT_W-1:0] match_cnt;
    logic [FILL_W-1:0]  fill;

    modport master (
        output din_valid, din, clear,
        input  match, match_cnt, fill
    );

    modport slave (
        input  din_valid, din, clear,
        output match, match_cnt, fill
    );

endinterface

// File: rtl/sat_counter.sv
// Clearable counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == CNT_MAX) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/serial_seq_detector.sv
// Serial pattern detector: shift history of accepted bits, registered match pulse and
// optional saturating match counter (built only when SEQ_DET_COUNT_EN is defined).
module serial_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 OVERLAP = 1,
    parameter int                 COUNT_W = DEF_COUNT_W
) (
    input logic                  clk,
    input logic                  reset,
    serial_seq_detector_if.slave bus
);

    localparam int                FILL_W   = fill_w(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] history_p0, history_p1;
    logic [FILL_W-1:0]  fill_p0, fill_p1;
    logic               match_p0, match_p1;
    logic [PAT_LEN-1:0] nh;
    logic               hit;
    hist_state_e        state;

    assign state = (fill_p1 == FILL_MAX) ? ARMED : FILLING;

    always_ff @(posedge clk) begin
        if (reset) begin
            history_p1 <= '0;
            fill_p1    <= '0;
            match_p1   <= 1'b0;
        end else begin
            history_p1 <= history_p0;
            fill_p1    <= fill_p0;
            match_p1   <= match_p0;
        end
    end

    // A hit is allowed on the bit that completes filling, so the test uses fill before the increment.
    always_comb begin
        history_p0 = history_p1;
        fill_p0    = fill_p1;
        match_p0   = 1'b0;
        hit        = 1'b0;
        nh         = {history_p1[PAT_LEN-2:0], bus.din};
        if (bus.clear) begin
            history_p0 = '0;
            fill_p0    = '0;
        end else if (bus.din_valid) begin
            hit        = (fill_p1 >= FILL_ARM) && (nh == PATTERN);
            history_p0 = nh;
            match_p0   = hit;
            if (hit && (OVERLAP == 0)) begin
                fill_p0 = '0;
            end else if (fill_p1 != FILL_MAX) begin
                fill_p0 = fill_p1 + FILL_W'(1);
            end
        end
    end

    // A fresh match leaves the history full when overlapping, empty otherwise.
    always_ff @(posedge clk) begin
        if (!reset && match_p1) begin
            assert (state == ((OVERLAP != 0) ? ARMED : FILLING));
        end
    end

    assign bus.match = match_p1;
    assign bus.fill  = fill_p1;

`ifdef SEQ_DET_COUNT_EN
    logic [COUNT_W-1:0] cnt;

    sat_counter #(
        .W (COUNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear),
        .inc   (match_p0),
        .cnt   (cnt)
    );

    assign bus.match_cnt = cnt;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_seq_detector.sv
// Bench for serial_seq_detector: overlapping, non-overlapping and 2-bit-counter instances share one stimulus.
module tb_serial_seq_detector;

    localparam int         PAT_LEN = 4;
    localparam logic [3:0] PAT     = 4'b1011;
`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_seq_detector_if #(.PAT_LEN(PAT_LEN), .COUNT_W(8)) if_ov ();
    serial_seq_detector_if #(.PAT_LEN(PAT_LEN), .COUNT_W(8)) if_no ();
    serial_seq_detector_if #(.PAT_LEN(PAT_LEN), .COUNT_W(2)) if_sat ();

    serial_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .OVERLAP(1), .COUNT_W(8))
        dut_ov (.clk(clk), .reset(reset), .bus(if_ov));
    serial_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .OVERLAP(0), .COUNT_W(8))
        dut_no (.clk(clk), .reset(reset), .bus(if_no));
    serial_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .OVERLAP(1), .COUNT_W(2))
        dut_sat (.clk(clk), .reset(reset), .bus(if_sat));

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    // Reference model: the accepted bit stream since the last reset/clear, and for each
    // instance the stream position where its current match search began.
    bit stream[$];
    int start[3];
    bit exp_m[3];
    int exp_c[3];
    bit ovl[3]  = '{1'b1, 1'b0, 1'b1};
    int cmax[3] = '{255, 255, 3};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
    endtask

    function automatic bit tail_is_pattern();
        int n = stream.size();
        logic [3:0] t;
        if (n < PAT_LEN) return 1'b0;
        t = {stream[n-4], stream[n-3], stream[n-2], stream[n-1]};
        return t == PAT;
    endfunction

    function automatic int exp_fill(input int k);
        int held = stream.size() - start[k];
        return (held > PAT_LEN) ? PAT_LEN : held;
    endfunction

    task automatic model_update(input bit r, input bit c, input bit v, input bit d);
        if (r || c) begin
            stream.delete();
            for (int k = 0; k < 3; k++) begin
                start[k] = 0;
                exp_m[k] = 1'b0;
                exp_c[k] = 0;
            end
        end else if (v) begin
            stream.push_back(d);
            for (int k = 0; k < 3; k++) begin
                bit hit;
                hit = (stream.size() - start[k] >= PAT_LEN) && tail_is_pattern();
                exp_m[k] = hit;
                if (hit) begin
                    if (exp_c[k] < cmax[k]) exp_c[k]++;
                    if (!ovl[k]) start[k] = stream.size();
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) exp_m[k] = 1'b0;
        end
    endtask

    function automatic int cnt_exp(input int v);
        return CNT_EN ? v : 0;
    endfunction

    task automatic compare_all();
        check("ov.match",  int'(if_ov.match),      int'(exp_m[0]));
        check("ov.fill",   int'(if_ov.fill),       exp_fill(0));
        check("ov.cnt",    int'(if_ov.match_cnt),  cnt_exp(exp_c[0]));
        check("no.match",  int'(if_no.match),      int'(exp_m[1]));
        check("no.fill",   int'(if_no.fill),       exp_fill(1));
        check("no.cnt",    int'(if_no.match_cnt),  cnt_exp(exp_c[1]));
        check("sat.match", int'(if_sat.match),     int'(exp_m[2]));
        check("sat.fill",  int'(if_sat.fill),      exp_fill(2));
        check("sat.cnt",   int'(if_sat.match_cnt), cnt_exp(exp_c[2]));
    endtask

    task automatic step(input bit r, input bit c, input bit v, input bit d);
        reset = r;
        if_ov.clear  = c; if_ov.din_valid  = v; if_ov.din  = d;
        if_no.clear  = c; if_no.din_valid  = v; if_no.din  = d;
        if_sat.clear = c; if_sat.din_valid = v; if_sat.din = d;
        @(posedge clk);
        #1;
        cycle++;
        model_update(r, c, v, d);
        compare_all();
    endtask

    typedef struct {
        bit r, c, v, d;
        bit m_ov; int f_ov; int n_ov;
        bit m_no; int f_no; int n_no;
    } vec_t;

    vec_t tbl[15];
    int   sat_seq[5];
    int   pulses;
    int   sat_idx;
    bit   bits4[4];
    bit   bits_sat[16];

    initial begin
        // Overlap / no-overlap stream 1,0,1,1,0,1,1, then reset, then clear colliding with the final 1.
        tbl[0]  = '{1, 0, 0, 0,  0, 0, 0,  0, 0, 0};
        tbl[1]  = '{0, 0, 1, 1,  0, 1, 0,  0, 1, 0};
        tbl[2]  = '{0, 0, 1, 0,  0, 2, 0,  0, 2, 0};
        tbl[3]  = '{0, 0, 1, 1,  0, 3, 0,  0, 3, 0};
        tbl[4]  = '{0, 0, 1, 1,  1, 4, 1,  1, 0, 1};
        tbl[5]  = '{0, 0, 1, 0,  0, 4, 1,  0, 1, 1};
        tbl[6]  = '{0, 0, 1, 1,  0, 4, 1,  0, 2, 1};
        tbl[7]  = '{0, 0, 1, 1,  1, 4, 2,  0, 3, 1};
        tbl[8]  = '{0, 0, 0, 0,  0, 4, 2,  0, 3, 1};
        tbl[9]  = '{1, 0, 0, 0,  0, 0, 0,  0, 0, 0};
        tbl[10] = '{0, 0, 1, 1,  0, 1, 0,  0, 1, 0};
        tbl[11] = '{0, 0, 1, 0,  0, 2, 0,  0, 2, 0};
        tbl[12] = '{0, 0, 1, 1,  0, 3, 0,  0, 3, 0};
        tbl[13] = '{0, 1, 1, 1,  0, 0, 0,  0, 0, 0};
        tbl[14] = '{0, 0, 0, 0,  0, 0, 0,  0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d);
            check("tbl.ov.match", int'(if_ov.match),     int'(tbl[i].m_ov));
            check("tbl.ov.fill",  int'(if_ov.fill),      tbl[i].f_ov);
            check("tbl.ov.cnt",   int'(if_ov.match_cnt), cnt_exp(tbl[i].n_ov));
            check("tbl.no.match", int'(if_no.match),     int'(tbl[i].m_no));
            check("tbl.no.fill",  int'(if_no.fill),      tbl[i].f_no);
            check("tbl.no.cnt",   int'(if_no.match_cnt), cnt_exp(tbl[i].n_no));
        end

        // Valid gaps of 3 idle cycles between 1,0,1,1.
        bits4 = '{1'b1, 1'b0, 1'b1, 1'b1};
        step(1, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, bits4[i]);
            pulses += int'(if_ov.match);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(0, 0, 0, 0);
                    pulses += int'(if_ov.match);
                end
            end
        end
        check("gap.final", int'(if_ov.match), 1);
        step(0, 0, 0, 0);
        check("gap.drop", int'(if_ov.match), 0);
        check("gap.pulses", pulses, 1);

        // Reset mid-pattern discards the partial history.
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        check("rst.match", int'(if_ov.match), 0);
        check("rst.fill", int'(if_ov.fill), 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        check("rst.rematch", int'(if_ov.match), 1);
        check("rst.cnt", int'(if_ov.match_cnt), cnt_exp(1));

        // Five overlapping matches against the 2-bit counter.
        sat_seq  = '{1, 2, 3, 3, 3};
        bits_sat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        step(1, 0, 0, 0);
        pulses  = 0;
        sat_idx = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, bits_sat[i]);
            if (if_sat.match) begin
                pulses++;
                if (sat_idx < 5) check("sat.seq", int'(if_sat.match_cnt), cnt_exp(sat_seq[sat_idx]));
                sat_idx++;
            end
        end
        check("sat.pulses", pulses, 5);

        // Randomized traffic with occasional reset and clear.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 100) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
